// File: rtl/prime_search_engine_pkg.sv
// Shared constants and types for the prime search engine and its remainder unit.
package prime_search_engine_pkg;

   localparam int DEF_WIDTH = 20;
   localparam int DIV_LAT   = DEF_WIDTH + 1;

   localparam logic [DEF_WIDTH-1:0] RESET_PRIME = 20'd888888;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      CHECK     = 3'd2,
      DIVIDE    = 3'd3,
      NEXT_CAND = 3'd4,
      DONE      = 3'd5
   } state_e;

endpackage

// File: rtl/prime_search_engine_if.sv
// Handshake between the prime-finder top level (master) and the search engine (slave).
interface prime_search_engine_if
   import prime_search_engine_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             en;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] largest_prime;
   logic             complete;
   logic             busy;

   modport master (output en, limit, input largest_prime, complete, busy);
   modport slave  (input en, limit, output largest_prime, complete, busy);
endinterface

// File: rtl/prime_mod_unit.sv
// Restoring sequential remainder unit: one dividend bit per cycle, done pulses WIDTH cycles after start.
module prime_mod_unit
   import prime_search_engine_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             RTC_Reset,
   input  logic             clr,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem,
   output logic             done
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] q_sh;
   logic [WIDTH-1:0] dvsr;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   trial;

   // Partial remainder shifted left with the next dividend bit; always < 2*divisor.
   assign trial = {rem, q_sh[WIDTH-1]};

   // NOTE: every flop here is written with <= so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge RTC_Reset) begin
      if (!RTC_Reset) begin
         q_sh <= '0;
         dvsr <= '0;
         rem  <= '0;
         cnt  <= '0;
         done <= 1'b0;
      end else if (clr) begin
         rem  <= '0;
         cnt  <= '0;
         done <= 1'b0;
      end else if (start) begin
         q_sh <= dividend;
         dvsr <= divisor;
         rem  <= '0;
         cnt  <= CNT_W'(WIDTH);
         done <= 1'b0;
      end else if (cnt != '0) begin
         rem  <= (trial >= {1'b0, dvsr}) ? WIDTH'(trial - {1'b0, dvsr}) : trial[WIDTH-1:0];
         q_sh <= {q_sh[WIDTH-2:0], 1'b0};
         cnt  <= cnt - CNT_W'(1);
         done <= (cnt == CNT_W'(1));
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/prime_search_engine.sv
// Finds the largest prime strictly below limit by trial division with odd divisors,
// stepping the candidate down until a prime (or nothing below 2) is found.
module prime_search_engine
   import prime_search_engine_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                 clk,
   input  logic                 RTC_Reset,
   prime_search_engine_if.slave bus
);
   state_e             state;
   logic [WIDTH-1:0]   cand;
   logic [WIDTH-1:0]   d;
   logic [WIDTH-1:0]   lp;
   logic [WIDTH-1:0]   rem;
   logic [2*WIDTH-1:0] d_sq;
   logic               div_start;
   logic               div_done;
   logic               cand_small;
   logic               cand_tiny_prime;
   logic               d_sq_over;

   // Full-width square so the bound test cannot overflow for any divisor value.
   assign d_sq            = (2*WIDTH)'(d) * (2*WIDTH)'(d);
   assign d_sq_over       = d_sq > (2*WIDTH)'(cand);
   assign cand_small      = cand < WIDTH'(2);
   assign cand_tiny_prime = (cand == WIDTH'(2)) || (cand == WIDTH'(3));
   assign div_start       = (state == CHECK) && bus.en && !cand_small && !cand_tiny_prime
                            && cand[0] && !d_sq_over;

   prime_mod_unit #(.WIDTH(WIDTH)) u_mod (
      .clk      (clk),
      .RTC_Reset(RTC_Reset),
      .clr      (!bus.en),
      .start    (div_start),
      .dividend (cand),
      .divisor  (d),
      .rem      (rem),
      .done     (div_done)
   );

   always_ff @(posedge clk or negedge RTC_Reset) begin
      if (!RTC_Reset) begin
         state <= IDLE;
         cand  <= '0;
         d     <= WIDTH'(3);
         lp    <= WIDTH'(RESET_PRIME);
      end else if (!bus.en) begin
         // Dropping en aborts any search or leaves DONE; the result is left untouched.
         state <= IDLE;
      end else begin
         case (state)
            IDLE: state <= LOAD;
            LOAD: begin
               cand  <= (bus.limit < WIDTH'(2)) ? '0 : bus.limit - WIDTH'(1);
               d     <= WIDTH'(3);
               state <= CHECK;
            end
            CHECK: begin
               if (cand_small) begin
                  lp    <= '0;
                  state <= DONE;
               end else if (cand_tiny_prime || (cand[0] && d_sq_over)) begin
                  lp    <= cand;
                  state <= DONE;
               end else if (!cand[0]) begin
                  state <= NEXT_CAND;
               end else begin
                  state <= DIVIDE;
               end
            end
            DIVIDE: begin
               if (div_done) begin
                  if (rem == '0) begin
                     state <= NEXT_CAND;
                  end else begin
                     d     <= d + WIDTH'(2);
                     state <= CHECK;
                  end
               end
            end
            NEXT_CAND: begin
               cand  <= cand - WIDTH'(1);
               d     <= WIDTH'(3);
               state <= CHECK;
            end
            DONE:    state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.largest_prime = lp;
   assign bus.complete      = (state == DONE);
   assign bus.busy          = (state == LOAD) || (state == CHECK) ||
                              (state == DIVIDE) || (state == NEXT_CAND);

endmodule

// File: tb/tb_prime_search_engine.sv
// Randomized bench: outputs are checked every cycle against a plain-arithmetic model of result and run length.
module tb_prime_search_engine;
   import prime_search_engine_pkg::*;

   localparam int W     = DEF_WIDTH;
   localparam int NEVER = 32'h7fff_ffff;

   logic clk       = 1'b0;
   logic RTC_Reset = 1'b0;

   prime_search_engine_if #(.WIDTH(W)) bus ();

   prime_search_engine #(.WIDTH(W)) dut (
      .clk      (clk),
      .RTC_Reset(RTC_Reset),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int n_vec   = 0;
   int n_err   = 0;
   int ecount  = 0;
   bit armed   = 1'b0;
   int s_edge  = 0;
   int d_edge  = NEVER;
   int run_cyc = 0;
   int old_lp  = 0;
   int new_lp  = 0;
   int cur_lp  = 0;
   int seen_c  = -1;

   always @(posedge clk) ecount <= ecount + 1;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Largest prime strictly below lim by exhaustive trial division.
   function automatic int ref_prime(input int lim);
      bit p;
      for (int c = lim - 1; c >= 2; c--) begin
         p = 1'b1;
         for (longint i = 2; i * i <= c; i++) begin
            if (c % i == 0) begin
               p = 1'b0;
               break;
            end
         end
         if (p) return c;
      end
      return 0;
   endfunction

   // Edges from the start edge until DONE is entered, from the published per-step costs.
   function automatic int ref_cycles(input int lim);
      int cand;
      int d;
      int cyc;
      cand = (lim < 2) ? 0 : lim - 1;
      d    = 3;
      cyc  = 1;
      while (cyc < 1000000) begin
         if (cand <= 3) return cyc + 1;
         if (cand % 2 == 0) begin
            cyc += 2;
            cand--;
            d = 3;
         end else if (longint'(d) * d > cand) begin
            return cyc + 1;
         end else begin
            cyc += 1 + DIV_LAT;
            if (cand % d == 0) begin
               cyc += 1;
               cand--;
               d = 3;
            end else begin
               d += 2;
            end
         end
      end
      return -1;
   endfunction

   // Per-cycle comparison against the model, sampled away from the clock edge.
   always begin
      int exp_b;
      int exp_c;
      int exp_l;
      int k;
      @(posedge clk);
      #2;
      if (!RTC_Reset) begin
         exp_b = 0; exp_c = 0; exp_l = RESET_PRIME;
      end else if (!armed || ecount < s_edge) begin
         exp_b = 0; exp_c = 0; exp_l = cur_lp;
      end else if (ecount >= d_edge) begin
         exp_b = 0; exp_c = 0;
         exp_l = (s_edge + run_cyc < d_edge) ? new_lp : old_lp;
      end else begin
         k     = ecount - s_edge;
         exp_b = (k < run_cyc) ? 1 : 0;
         exp_c = (k >= run_cyc) ? 1 : 0;
         exp_l = (k >= run_cyc) ? new_lp : old_lp;
      end
      check("busy", int'(bus.busy), exp_b);
      check("complete", int'(bus.complete), exp_c);
      check("largest_prime", int'(bus.largest_prime), exp_l);
      if (armed && RTC_Reset && seen_c < 0 && bus.complete) seen_c = ecount - s_edge;
   end

   // lit/lit_lat < 0 skip the literal checks; abort_after >= 0 cuts the run short.
   task automatic run(input int lim, input int lit, input int lit_lat,
                      input int abort_after, input bit by_reset);
      @(negedge clk);
      bus.limit = W'(lim);
      old_lp    = cur_lp;
      new_lp    = ref_prime(lim);
      run_cyc   = ref_cycles(lim);
      s_edge    = ecount + 1;
      d_edge    = NEVER;
      seen_c    = -1;
      armed     = 1'b1;
      bus.en    = 1'b1;
      if (abort_after < 0) begin
         repeat (2) @(negedge clk);
         bus.limit = W'($urandom);
         repeat (run_cyc) @(negedge clk);
         check("run_complete", int'(bus.complete), 1);
         if (lit >= 0) check("run_result", int'(bus.largest_prime), lit);
         if (lit_lat >= 0) check("run_latency", seen_c, lit_lat);
         d_edge = ecount + 1;
         bus.en = 1'b0;
         repeat (2) @(negedge clk);
         check("rearm_complete", int'(bus.complete), 0);
         cur_lp = new_lp;
      end else begin
         repeat (abort_after) @(negedge clk);
         if (by_reset) begin
            #2;
            RTC_Reset = 1'b0;
            bus.en    = 1'b0;
            #1;
            check("async_rst_lp", int'(bus.largest_prime), 888888);
            check("async_rst_busy", int'(bus.busy), 0);
            check("async_rst_complete", int'(bus.complete), 0);
            armed  = 1'b0;
            cur_lp = RESET_PRIME;
            repeat (2) @(negedge clk);
            RTC_Reset = 1'b1;
            @(negedge clk);
         end else begin
            d_edge = ecount + 1;
            bus.en = 1'b0;
            repeat (2) @(negedge clk);
            cur_lp = (s_edge + run_cyc < d_edge) ? new_lp : old_lp;
            check("abort_busy", int'(bus.busy), 0);
            check("abort_complete", int'(bus.complete), 0);
            check("abort_lp", int'(bus.largest_prime), cur_lp);
         end
      end
   endtask

   initial begin
      bus.en    = 1'b0;
      bus.limit = W'(1000);
      cur_lp    = RESET_PRIME;
      repeat (3) @(negedge clk);
      check("reset_lp", int'(bus.largest_prime), 888888);
      check("reset_complete", int'(bus.complete), 0);
      check("reset_busy", int'(bus.busy), 0);
      RTC_Reset = 1'b1;
      repeat (2) @(negedge clk);

      run(1000, 997, -1, -1, 1'b0);
      run(11, 7, -1, -1, 1'b0);
      run(3, 2, -1, -1, 1'b0);
      run(2, 0, 2, -1, 1'b0);
      run(0, 0, 2, -1, 1'b0);
      run(1, 0, 2, -1, 1'b0);
      run(1048575, 1048573, -1, -1, 1'b0);

      // Abort inside the first division of the limit=1000 search, then rerun it.
      run(1000, -1, -1, 9, 1'b0);
      check("abort_kept_old", int'(bus.largest_prime), 1048573);
      run(1000, 997, -1, -1, 1'b0);

      run(100, -1, -1, 15, 1'b1);
      run(100, 97, -1, -1, 1'b0);

      for (int i = 0; i < 6; i++) run(int'($urandom_range(0, 4000)), -1, -1, -1, 1'b0);
      for (int i = 0; i < 2; i++)
         run(int'($urandom_range(0, 4000)), -1, -1, int'($urandom_range(3, 40)), 1'b0);
      run(int'($urandom_range(0, 4000)), -1, -1, -1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
